// File: rtl/ldpc_cw_tx_scheduler.sv
// ldpc_cw_tx_scheduler
//   Round-robin scheduler between the LDPC encoder cores and the shared
//   codeword serializer. One core is granted at a time. Its codeword is
//   captured into a shift register and streamed MSB-first as OUT_WIDTH-bit
//   beats with valid/ready backpressure.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   i_req_valid  per-core codeword available
//   i_req_data   core i codeword at [i*CW_WIDTH +: CW_WIDTH]
//   o_req_ready  one-hot accept pulse for the granted core
//   o_out_valid  beat valid
//   i_out_ready  downstream accepts beat
//   o_out_data   beat data, codeword MSB-first
//   o_out_last   final beat of the codeword
//   o_out_src    index of the core owning the current codeword
//   o_busy       codeword in flight
module ldpc_cw_tx_scheduler #(
    parameter int N_REQ     = 2,
    parameter int CW_WIDTH  = 648,
    parameter int OUT_WIDTH = 32,
    parameter int BEATS     = (CW_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH,
    parameter int SRC_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*CW_WIDTH-1:0] i_req_data,
    output logic [N_REQ-1:0]          o_req_ready,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [OUT_WIDTH-1:0]      o_out_data,
    output logic                      o_out_last,
    output logic [SRC_W-1:0]          o_out_src,
    output logic                      o_busy
);

    // The shift register is a whole number of beats wide. The codeword sits
    // left-justified in it, so a short final beat comes out with zero low bits.
    localparam int SR_W  = BEATS * OUT_WIDTH;
    localparam int PAD   = SR_W - CW_WIDTH;
    localparam int CNT_W = $clog2(BEATS + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]          r_state;
    logic [SRC_W-1:0]    r_ptr;
    logic [SRC_W-1:0]    r_src;
    logic [CNT_W-1:0]    r_cnt;
    logic [SR_W-1:0]     r_sr;

    logic                w_send;
    logic                w_last;
    logic                w_hs;
    logic                w_found;
    logic                w_load;
    logic [SRC_W-1:0]    w_grant;
    logic [SRC_W-1:0]    w_idx;
    logic [CW_WIDTH-1:0] w_cw;

    // (a + b) mod N_REQ, where a < N_REQ and b < N_REQ.
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= N_REQ) s = s - N_REQ;
        return SRC_W'(s);
    endfunction

    assign w_send = (r_state == ST_SEND);
    assign w_last = w_send && (r_cnt == CNT_W'(BEATS - 1));
    assign w_hs   = w_send && i_out_ready;

    // The search starts at the pointer and wraps. The first valid core wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = wrap_add(r_ptr, k);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    // A load can happen when idle, or on the same cycle as the last beat's
    // handshake. This back-to-back load is what removes the gap between
    // codewords. The rst term holds req_ready low while reset is asserted.
    assign w_load = rst && w_found && (!w_send || (w_hs && w_last));
    assign w_cw   = i_req_data[w_grant*CW_WIDTH +: CW_WIDTH];

    always_comb begin
        o_req_ready = '0;
        if (w_load) o_req_ready[w_grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_src   <= '0;
            r_cnt   <= '0;
            r_sr    <= '0;
        end else if (w_load) begin
            r_state <= ST_SEND;
            r_sr    <= SR_W'(w_cw) << PAD;
            r_cnt   <= '0;
            r_src   <= w_grant;
            r_ptr   <= wrap_add(w_grant, 1);
        end else if (w_hs) begin
            r_sr    <= r_sr << OUT_WIDTH;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) r_state <= ST_IDLE;
        end
    end

    assign o_out_valid = w_send;
    assign o_busy      = w_send;
    assign o_out_last  = w_last;
    assign o_out_data  = r_sr[SR_W-1 -: OUT_WIDTH];
    assign o_out_src   = r_src;

endmodule
